// File: rtl/nn_pkg.sv
// Shared definitions for the sliding-window feeder: FSM states, mode codes and fill depths.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_3COL = 2'b00;
  localparam logic [2:0] FILL_3    = 3'd3;
  localparam logic [2:0] FILL_6    = 3'd6;

  // Columns needed before the first window is complete.
  function automatic logic [2:0] fill_len(input logic [1:0] mode);
    return (mode == MODE_3COL) ? FILL_3 : FILL_6;
  endfunction

endpackage

// File: rtl/nn_sld_rd_pipe.sv
// Two-stage read pipe: tracks outstanding SRAM reads and captures the returned
// column word so it reaches the register file two cycles after issue.
module nn_sld_rd_pipe #(
  parameter int WIDTH = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_en,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_shift,
  output logic             o_busy
);

  logic stage1;
  logic stage2;

  // SRAM data is valid while stage1 is set; it is held until the next read returns.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      o_data <= '0;
    end else begin
      stage1 <= i_rd_en;
      stage2 <= stage1;
      if (stage1) o_data <= i_rd_data;
    end
  end

  assign o_shift = stage2;
  assign o_busy  = stage1 | stage2;

endmodule

// File: rtl/nn_sld_feeder.sv
// Walks one image band column by column, fills the sliding window, then slides it by
// the stride for each further window, holding each full window until the PE accepts it.
module nn_sld_feeder
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 6,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [1:0]                    i_mode,
  input  logic                          i_3x3,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  input  logic [COL_WIDTH-1:0]          i_img_w,
  input  logic [1:0]                    i_stride,
  output logic                          o_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_rd_addr,
  input  logic [DATA_WIDTH*ROW_NUM-1:0] i_rd_data,
  output logic [DATA_WIDTH*ROW_NUM-1:0] o_data,
  output logic                          o_shift,
  output logic [1:0]                    o_mode,
  output logic                          o_3x3,
  output logic                          o_win_valid,
  input  logic                          i_pe_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int WORD_W = DATA_WIDTH * ROW_NUM;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [COL_WIDTH-1:0]  img_w_q;
  logic [1:0]            stride_q;
  logic [COL_WIDTH-1:0]  col;
  logic [2:0]            issued;
  logic [2:0]            shifted;
  logic [2:0]            fill_n;
  logic [2:0]            target;
  logic [COL_WIDTH:0]    col_step;
  logic                  start_ok;
  logic                  too_narrow;
  logic                  can_read;
  logic                  phase_done;
  logic                  pipe_busy;

  assign start_ok   = (state == ST_IDLE) && i_start;
  assign fill_n     = fill_len(o_mode);
  assign target     = (state == ST_FILL) ? fill_n : {1'b0, stride_q};
  assign col_step   = {1'b0, col} + (COL_WIDTH+1)'(stride_q);
  assign too_narrow = img_w_q < COL_WIDTH'(fill_n);
  assign can_read   = (issued < target) && (col < img_w_q);
  assign phase_done = (issued == target) && (shifted == issued) && !pipe_busy;
  assign o_rd_addr  = base_q + ADDR_WIDTH'(col);

  // Band configuration is captured only when a start is accepted from IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_mode   <= 2'b00;
      o_3x3    <= 1'b0;
      base_q   <= '0;
      img_w_q  <= '0;
      stride_q <= 2'd0;
    end else if (start_ok) begin
      o_mode   <= i_mode;
      o_3x3    <= i_3x3;
      base_q   <= i_base_addr;
      img_w_q  <= i_img_w;
      stride_q <= (i_stride == 2'd0) ? 2'd1 : i_stride;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_rd_en     = 1'b0;
    o_busy      = 1'b0;
    o_win_valid = 1'b0;
    o_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_FILL;
      end
      ST_FILL: begin
        o_busy = 1'b1;
        if (too_narrow) begin
          state_next = ST_DONE;
        end else begin
          o_rd_en = can_read;
          if (phase_done) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_busy      = 1'b1;
        o_win_valid = 1'b1;
        if (i_pe_ready)
          state_next = (col_step <= {1'b0, img_w_q}) ? ST_STEP : ST_DONE;
      end
      ST_STEP: begin
        o_busy  = 1'b1;
        o_rd_en = can_read;
        if (phase_done) state_next = ST_WAIT;
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // issued/shifted count per phase (fill or one slide); col only advances on a read,
  // and a read needs col < width, so col saturates at the band width.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col     <= '0;
      issued  <= 3'd0;
      shifted <= 3'd0;
    end else if (start_ok) begin
      col     <= '0;
      issued  <= 3'd0;
      shifted <= 3'd0;
    end else if (state == ST_WAIT && i_pe_ready) begin
      issued  <= 3'd0;
      shifted <= 3'd0;
    end else begin
      if (o_rd_en) begin
        issued <= issued + 3'd1;
        col    <= col + 1'b1;
      end
      if (o_shift) shifted <= shifted + 3'd1;
    end
  end

  nn_sld_rd_pipe #(
    .WIDTH(WORD_W)
  ) u_rd_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rd_en  (o_rd_en),
    .i_rd_data(i_rd_data),
    .o_data   (o_data),
    .o_shift  (o_shift),
    .o_busy   (pipe_busy)
  );

endmodule

// File: tb/tb_nn_sld_feeder.sv
// Self-checking bench for nn_sld_feeder: table-driven and random bands checked against a
// transaction-level model of the expected read addresses, shifted words and window counts.
module tb_nn_sld_feeder;

  typedef struct {
    logic [1:0] mode;
    logic       sel;
    logic [9:0] base;
    logic [7:0] img_w;
    logic [1:0] stride;
    int         ready_pat;
    bit         glitch;
    int         exp_windows;
    int         exp_reads;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_mode;
  logic        i_3x3;
  logic [9:0]  i_base_addr;
  logic [7:0]  i_img_w;
  logic [1:0]  i_stride;
  logic        o_rd_en;
  logic [9:0]  o_rd_addr;
  logic [47:0] i_rd_data;
  logic [47:0] o_data;
  logic        o_shift;
  logic [1:0]  o_mode;
  logic        o_3x3;
  logic        o_win_valid;
  logic        i_pe_ready;
  logic        o_busy;
  logic        o_done;

  int total = 0;
  int bad   = 0;

  // monitor state, cleared at the start of every band
  logic [9:0]  rd_q[$];
  logic [47:0] sh_q[$];
  int          win_sh_q[$];
  int cyc = 0, start_cyc, done_cyc, done_cnt, acc_cnt, exp_windows_mon;
  int lat_err, wait_err, resume_err, busy_err, shifts_since, wv_run;
  logic h1, h2, prev_wv, prev_acc;
  logic [47:0] prev_data;
  logic [63:0] garb;

  vec_t tbl[9];

  nn_sld_feeder dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_3x3      (i_3x3),
    .i_base_addr(i_base_addr),
    .i_img_w    (i_img_w),
    .i_stride   (i_stride),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_data     (o_data),
    .o_shift    (o_shift),
    .o_mode     (o_mode),
    .o_3x3      (o_3x3),
    .o_win_valid(o_win_valid),
    .i_pe_ready (i_pe_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [47:0] memf(input logic [9:0] a);
    logic [9:0] b;
    b = a + 10'd37;
    return {6'h2A, a, 4'h5, ~a, 4'hC, b, 4'h3};
  endfunction

  function automatic int fill_of(input logic [1:0] mode);
    return (mode == 2'b00) ? 3 : 6;
  endfunction

  function automatic int eff_stride(input logic [1:0] s);
    return (s == 2'd0) ? 1 : int'(s);
  endfunction

  function automatic int model_windows(input logic [1:0] mode, input logic [7:0] w,
                                       input logic [1:0] s);
    if (int'(w) < fill_of(mode)) return 0;
    return (int'(w) - fill_of(mode)) / eff_stride(s) + 1;
  endfunction

  function automatic int model_reads(input logic [1:0] mode, input logic [7:0] w,
                                     input logic [1:0] s);
    int n;
    n = model_windows(mode, w, s);
    return (n == 0) ? 0 : fill_of(mode) + (n - 1) * eff_stride(s);
  endfunction

  // SRAM model: data for the address read in the previous cycle, garbage otherwise.
  always @(posedge i_clk) begin
    garb = {$urandom(), $urandom()};
    i_rd_data <= o_rd_en ? memf(o_rd_addr) : garb[47:0];
  end

  // Protocol monitor, sampling on the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    if (!i_rst) begin
      h1 = 1'b0; h2 = 1'b0; prev_wv = 1'b0; prev_acc = 1'b0; wv_run = 0;
    end else begin
      if (i_start && !o_busy && start_cyc < 0) start_cyc = cyc;
      if (o_rd_en) rd_q.push_back(o_rd_addr);
      if (o_shift != h2) lat_err++;
      if (o_shift) begin
        sh_q.push_back(o_data);
        shifts_since++;
      end
      if (o_win_valid && !prev_wv) begin
        win_sh_q.push_back(shifts_since);
        shifts_since = 0;
      end
      if (o_win_valid && (o_rd_en || h1 || h2 || o_shift)) wait_err++;
      if (o_win_valid && prev_wv && o_data != prev_data) wait_err++;
      if (prev_acc && o_win_valid) wait_err++;
      if (prev_acc) begin
        acc_cnt++;
        if (acc_cnt < exp_windows_mon && !o_rd_en) resume_err++;
      end
      if (o_win_valid && !o_busy) busy_err++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (o_busy) busy_err++;
      end
      wv_run    = o_win_valid ? wv_run + 1 : 0;
      h2        = h1;
      h1        = o_rd_en;
      prev_wv   = o_win_valid;
      prev_acc  = o_win_valid && i_pe_ready;
      prev_data = o_data;
    end
  end

  task automatic clearMon(input int exp_win);
    rd_q.delete(); sh_q.delete(); win_sh_q.delete();
    start_cyc = -1; done_cyc = 0; done_cnt = 0; acc_cnt = 0;
    lat_err = 0; wait_err = 0; resume_err = 0; busy_err = 0; shifts_since = 0;
    exp_windows_mon = exp_win;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
  endtask

  task automatic scrambleCfg();
    i_mode      = 2'($urandom());
    i_3x3       = 1'($urandom());
    i_base_addr = 10'($urandom());
    i_img_w     = 8'($urandom());
    i_stride    = 2'($urandom());
  endtask

  // Runs one band to completion with the requested PE-ready pattern.
  task automatic applyStimulus(input vec_t v);
    clearMon(v.exp_windows);
    @(posedge i_clk); #1;
    i_mode = v.mode; i_3x3 = v.sel; i_base_addr = v.base;
    i_img_w = v.img_w; i_stride = v.stride; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    scrambleCfg();
    for (int k = 0; k < 3000; k++) begin
      case (v.ready_pat)
        0:       i_pe_ready = 1'b1;
        1:       i_pe_ready = 1'($urandom_range(0, 1));
        default: i_pe_ready = (wv_run >= 10);
      endcase
      i_start = v.glitch && (k % 7 == 3);
      if (i_start) scrambleCfg();
      @(posedge i_clk); #1;
      if (done_cnt > 0) break;
    end
    i_start = 1'b0;
    i_pe_ready = 1'b0;
    checkOutput("band_finished", 64'(done_cnt > 0), 64'd1);
    if (done_cnt == 0) doReset();
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic checkBand(input vec_t v, input string tag);
    int addr_bad = 0, data_bad = 0, ws_bad = 0, want;
    checkOutput({tag, "_nreads"}, rd_q.size(), v.exp_reads);
    foreach (rd_q[i]) if (rd_q[i] !== 10'(int'(v.base) + i)) addr_bad++;
    checkOutput({tag, "_addr_seq"}, addr_bad, 0);
    checkOutput({tag, "_nshifts"}, sh_q.size(), v.exp_reads);
    foreach (sh_q[i]) if (sh_q[i] !== memf(10'(int'(v.base) + i))) data_bad++;
    checkOutput({tag, "_shift_data"}, data_bad, 0);
    checkOutput({tag, "_windows"}, win_sh_q.size(), v.exp_windows);
    foreach (win_sh_q[i]) begin
      want = (i == 0) ? fill_of(v.mode) : eff_stride(v.stride);
      if (win_sh_q[i] != want) ws_bad++;
    end
    checkOutput({tag, "_win_shifts"}, ws_bad, 0);
    checkOutput({tag, "_done_cnt"}, done_cnt, 1);
    checkOutput({tag, "_shift_latency"}, lat_err, 0);
    checkOutput({tag, "_wait_rules"}, wait_err, 0);
    checkOutput({tag, "_resume"}, resume_err, 0);
    checkOutput({tag, "_busy"}, busy_err, 0);
    checkOutput({tag, "_mode_latch"}, {o_3x3, o_mode}, {v.sel, v.mode});
    if (v.exp_windows == 0) checkOutput({tag, "_short_done_lat"}, done_cyc - start_cyc, 2);
  endtask

  initial begin
    vec_t v;
    i_rst = 1'b0; i_start = 1'b0; i_pe_ready = 1'b0;
    i_mode = 2'b00; i_3x3 = 1'b0; i_base_addr = '0; i_img_w = '0; i_stride = '0;
    clearMon(0);

    //            mode   sel   base     w      s    rdy glitch win reads
    tbl[0] = '{2'b01, 1'b0, 10'h100, 8'd8,  2'd1, 0, 1'b0, 3, 8};
    tbl[1] = '{2'b00, 1'b1, 10'h040, 8'd9,  2'd3, 0, 1'b0, 3, 9};
    tbl[2] = '{2'b10, 1'b0, 10'h200, 8'd4,  2'd0, 0, 1'b0, 0, 0};
    tbl[3] = '{2'b00, 1'b0, 10'h010, 8'd10, 2'd2, 2, 1'b0, 4, 9};
    tbl[4] = '{2'b11, 1'b1, 10'h3FC, 8'd7,  2'd0, 1, 1'b1, 2, 7};
    tbl[5] = '{2'b00, 1'b0, 10'h155, 8'd3,  2'd3, 1, 1'b0, 1, 3};
    tbl[6] = '{2'b01, 1'b1, 10'h0A0, 8'd6,  2'd2, 0, 1'b1, 1, 6};
    tbl[7] = '{2'b00, 1'b0, 10'h000, 8'd2,  2'd1, 0, 1'b1, 0, 0};
    tbl[8] = '{2'b01, 1'b0, 10'h300, 8'd20, 2'd3, 1, 1'b1, 5, 18};

    #12;
    checkOutput("reset_ctrl",
                {o_rd_en, o_rd_addr, o_shift, o_mode, o_3x3, o_win_valid, o_busy, o_done}, 0);
    checkOutput("reset_data", o_data, 0);
    @(posedge i_clk); #1 i_rst = 1'b1;

    // Reset asserted in the middle of a fill must clear everything at once.
    clearMon(3);
    @(posedge i_clk); #1;
    i_mode = 2'b01; i_base_addr = 10'h100; i_img_w = 8'd8; i_stride = 2'd1; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int k = 0; k < 50 && rd_q.size() < 3; k++) begin
      @(posedge i_clk); #1;
    end
    checkOutput("rst_midfill_reached", 64'(rd_q.size() >= 3), 64'd1);
    i_rst = 1'b0;
    #1;
    checkOutput("rst_midfill_ctrl",
                {o_rd_en, o_rd_addr, o_shift, o_mode, o_3x3, o_win_valid, o_busy, o_done}, 0);
    checkOutput("rst_midfill_data", o_data, 0);
    @(posedge i_clk); #1 i_rst = 1'b1;
    clearMon(0);
    repeat (20) @(posedge i_clk);
    #1;
    checkOutput("rst_no_activity", rd_q.size() + sh_q.size() + done_cnt, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkBand(tbl[i], $sformatf("tbl%0d", i));
    end

    for (int r = 0; r < 10; r++) begin
      v.mode        = 2'($urandom_range(0, 3));
      v.sel         = 1'($urandom());
      v.base        = 10'($urandom());
      v.img_w       = 8'($urandom_range(0, 24));
      v.stride      = 2'($urandom_range(0, 3));
      v.ready_pat   = $urandom_range(0, 2);
      v.glitch      = 1'($urandom());
      v.exp_windows = model_windows(v.mode, v.img_w, v.stride);
      v.exp_reads   = model_reads(v.mode, v.img_w, v.stride);
      applyStimulus(v);
      checkBand(v, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
